// File: rtl/uart_loader_ctrl.sv
// -----------------------------------------------------------------------------
// uart_loader_ctrl
//
// Purpose: sequences the UART program loader. Each line offered by UartInput is
// captured, written to memory over a req/ack port at incrementing line-aligned
// addresses, and acknowledged back to UartInput with a one-cycle done strobe.
// The CPU is held in reset until totalMemoryWriteSize bytes have been committed.
//
// Optional feature: define UART_LOADER_TIMEOUT_EN to enable an ack watchdog.
// With it, a write that sees no ack for TimeoutCycles cycles is abandoned, the
// sticky loadError flag is raised and the block parks in an error state that
// keeps the CPU in reset. Without it, loadError is tied low and a write waits
// for its ack indefinitely.
//
// Ports:
//   clk                  in   system clock
//   rstN                 in   async active-low reset
//   totalMemoryWriteSize in   image size in bytes (0 = never finish)
//   uartWriteEnable      in   line valid, held until uartWriteDone
//   uartWriteValue       in   line data
//   uartWriteDone        out  one-cycle line-consumed strobe
//   memWriteReq          out  write request, held until memWriteAck
//   memWriteAddr         out  line-aligned byte address
//   memWriteValue        out  registered line data
//   memWriteAck          in   memory accepted the write this cycle
//   bytesWritten         out  saturating count of committed bytes
//   loadDone             out  image fully written (level)
//   cpuResetN            out  CPU reset, released once loadDone
//   loadError            out  sticky ack-timeout flag
// -----------------------------------------------------------------------------
module uart_loader_ctrl #(
   parameter int unsigned          LineSize      = 4,
   parameter int unsigned          ByteWidth     = 8,
   parameter int unsigned          AddrWidth     = 32,
   parameter logic [AddrWidth-1:0] BaseAddr      = '0,
   parameter int unsigned          TimeoutCycles = 1024
) (
   input  logic                          clk,
   input  logic                          rstN,
   input  logic [31:0]                   totalMemoryWriteSize,
   input  logic                          uartWriteEnable,
   input  logic [LineSize*ByteWidth-1:0] uartWriteValue,
   output logic                          uartWriteDone,
   output logic                          memWriteReq,
   output logic [AddrWidth-1:0]          memWriteAddr,
   output logic [LineSize*ByteWidth-1:0] memWriteValue,
   input  logic                          memWriteAck,
   output logic [31:0]                   bytesWritten,
   output logic                          loadDone,
   output logic                          cpuResetN,
   output logic                          loadError
);

   localparam int unsigned LineWidth = LineSize * ByteWidth;
   localparam logic [AddrWidth-1:0] AddrInc = AddrWidth'(LineSize);
   localparam logic [31:0] ByteInc = 32'(LineSize);

   localparam logic [2:0] StIdle  = 3'd0;
   localparam logic [2:0] StWrite = 3'd1;
   localparam logic [2:0] StAcked = 3'd2;
   localparam logic [2:0] StDone  = 3'd3;
`ifdef UART_LOADER_TIMEOUT_EN
   localparam logic [2:0] StError = 3'd4;
`endif

   logic [2:0]           r_state,     w_state;
   logic                 r_uart_done, w_uart_done;
   logic                 r_req,       w_req;
   logic [AddrWidth-1:0] r_addr,      w_addr;
   logic [LineWidth-1:0] r_value,     w_value;
   logic [31:0]          r_bytes,     w_bytes;
   logic                 r_load_done, w_load_done;
   logic                 r_cpu_rst_n, w_cpu_rst_n;
   logic                 r_error,     w_error;
`ifdef UART_LOADER_TIMEOUT_EN
   logic [31:0]          r_tcnt,      w_tcnt;
`else
   logic                 w_unused_timeout;
   assign w_unused_timeout = ^TimeoutCycles;
`endif

   always_comb begin
      w_state     = r_state;
      w_uart_done = 1'b0;
      w_req       = r_req;
      w_addr      = r_addr;
      w_value     = r_value;
      w_bytes     = r_bytes;
      w_load_done = r_load_done;
      w_cpu_rst_n = r_cpu_rst_n;
      w_error     = r_error;
`ifdef UART_LOADER_TIMEOUT_EN
      w_tcnt      = r_tcnt;
`endif
      case (r_state)
         StIdle: begin
            if (uartWriteEnable) begin
               w_value = uartWriteValue;
               w_req   = 1'b1;
               w_state = StWrite;
            end
         end
         StWrite: begin
            if (memWriteAck) begin
               w_req       = 1'b0;
               w_uart_done = 1'b1;
               w_addr      = r_addr + AddrInc;
               // Saturate so a runaway stream never wraps the count back below size.
               w_bytes     = (r_bytes > (32'hFFFF_FFFF - ByteInc)) ? 32'hFFFF_FFFF
                                                                 : r_bytes + ByteInc;
               w_state     = StAcked;
`ifdef UART_LOADER_TIMEOUT_EN
               w_tcnt      = '0;
            end else if (r_tcnt == TimeoutCycles - 1) begin
               w_req   = 1'b0;
               w_error = 1'b1;
               w_tcnt  = '0;
               w_state = StError;
            end else begin
               w_tcnt = r_tcnt + 32'd1;
`endif
            end
         end
         StAcked: begin
            // Size of zero means an open-ended stream: keep accepting lines.
            if ((totalMemoryWriteSize != 32'd0) && (r_bytes >= totalMemoryWriteSize)) begin
               w_load_done = 1'b1;
               w_cpu_rst_n = 1'b1;
               w_state     = StDone;
            end else begin
               w_state = StIdle;
            end
         end
         StDone: begin
            // Drain trailing lines without writing; skip the cycle the strobe is
            // already up so a still-held enable is not acked twice.
            if (uartWriteEnable && !r_uart_done) w_uart_done = 1'b1;
         end
`ifdef UART_LOADER_TIMEOUT_EN
         StError: begin
            if (uartWriteEnable && !r_uart_done) w_uart_done = 1'b1;
         end
`endif
         default: w_state = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         r_state     <= StIdle;
         r_uart_done <= 1'b0;
         r_req       <= 1'b0;
         r_addr      <= BaseAddr;
         r_value     <= '0;
         r_bytes     <= '0;
         r_load_done <= 1'b0;
         r_cpu_rst_n <= 1'b0;
         r_error     <= 1'b0;
`ifdef UART_LOADER_TIMEOUT_EN
         r_tcnt      <= '0;
`endif
      end else begin
         r_state     <= w_state;
         r_uart_done <= w_uart_done;
         r_req       <= w_req;
         r_addr      <= w_addr;
         r_value     <= w_value;
         r_bytes     <= w_bytes;
         r_load_done <= w_load_done;
         r_cpu_rst_n <= w_cpu_rst_n;
         r_error     <= w_error;
`ifdef UART_LOADER_TIMEOUT_EN
         r_tcnt      <= w_tcnt;
`endif
      end
   end

   assign uartWriteDone = r_uart_done;
   assign memWriteReq   = r_req;
   assign memWriteAddr  = r_addr;
   assign memWriteValue = r_value;
   assign bytesWritten  = r_bytes;
   assign loadDone      = r_load_done;
   assign cpuResetN     = r_cpu_rst_n;
   assign loadError     = r_error;

endmodule

// File: tb/tb_uart_loader_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_loader_ctrl
//
// Directed bench for uart_loader_ctrl: acts as UartInput and as the memory
// port, with hand-computed expected addresses, data, counts and flags.
// -----------------------------------------------------------------------------
module tb_uart_loader_ctrl;

   localparam int unsigned TbTimeout = 16;

   logic        clk = 1'b0;
   logic        rstN;
   logic [31:0] totalMemoryWriteSize;
   logic        uartWriteEnable;
   logic [31:0] uartWriteValue;
   logic        uartWriteDone;
   logic        memWriteReq;
   logic [31:0] memWriteAddr;
   logic [31:0] memWriteValue;
   logic        memWriteAck;
   logic [31:0] bytesWritten;
   logic        loadDone;
   logic        cpuResetN;
   logic        loadError;

   int n_checks = 0;
   int n_errors = 0;
   int done_cnt = 0;
   int wr_cnt   = 0;

   uart_loader_ctrl #(
      .LineSize      (4),
      .ByteWidth     (8),
      .AddrWidth     (32),
      .BaseAddr      (32'h0),
      .TimeoutCycles (TbTimeout)
   ) u_dut (
      .clk                  (clk),
      .rstN                 (rstN),
      .totalMemoryWriteSize (totalMemoryWriteSize),
      .uartWriteEnable      (uartWriteEnable),
      .uartWriteValue       (uartWriteValue),
      .uartWriteDone        (uartWriteDone),
      .memWriteReq          (memWriteReq),
      .memWriteAddr         (memWriteAddr),
      .memWriteValue        (memWriteValue),
      .memWriteAck          (memWriteAck),
      .bytesWritten         (bytesWritten),
      .loadDone             (loadDone),
      .cpuResetN            (cpuResetN),
      .loadError            (loadError)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (uartWriteDone) done_cnt++;
      if (memWriteReq && memWriteAck) wr_cnt++;
   end

   task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check_val({tag, "_done"},  uartWriteDone, 0);
      check_val({tag, "_req"},   memWriteReq,   0);
      check_val({tag, "_addr"},  memWriteAddr,  32'h0);
      check_val({tag, "_value"}, memWriteValue, 32'h0);
      check_val({tag, "_bytes"}, bytesWritten,  32'd0);
      check_val({tag, "_ldone"}, loadDone,      0);
      check_val({tag, "_cpurn"}, cpuResetN,     0);
      check_val({tag, "_lerr"},  loadError,     0);
   endtask

   task automatic do_reset();
      uartWriteEnable = 1'b0;
      memWriteAck     = 1'b0;
      #2 rstN = 1'b0;
      cycle();
      cycle();
      rstN = 1'b1;
      cycle();
   endtask

   task automatic wait_req(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (memWriteReq) begin
            ok = 1'b1;
            break;
         end
         cycle();
      end
   endtask

   // Offer one line, hold ack low for d cycles of req, then ack for one cycle.
   task automatic send_line(input logic [31:0] val, input int d, input logic [31:0] exp_addr);
      int dc0;
      bit ok;
      dc0 = done_cnt;
      uartWriteValue  = val;
      uartWriteEnable = 1'b1;
      wait_req(ok);
      if (!ok) begin
         check_val("req_timeout", 0, 1);
         uartWriteEnable = 1'b0;
      end else begin
         for (int i = 0; i < d; i++) begin
            check_val("req_hold", memWriteReq, 1);
            check_val("addr", memWriteAddr, exp_addr);
            check_val("value", memWriteValue, val);
            check_val("no_early_done", uartWriteDone, 0);
            cycle();
         end
         memWriteAck = 1'b1;
         cycle();
         memWriteAck = 1'b0;
         check_val("done_pulse", uartWriteDone, 1);
         check_val("req_drop", memWriteReq, 0);
         uartWriteEnable = 1'b0;
         cycle();
         check_val("done_low", uartWriteDone, 0);
         check_val("done_once", done_cnt - dc0, 1);
      end
   endtask

   initial begin
      bit ok;
      bit seen_req;
      bit seen_done;
      int dc0;
      int wc0;
      int cnt;

      rstN                 = 1'b0;
      totalMemoryWriteSize = 32'd8;
      uartWriteEnable      = 1'b0;
      uartWriteValue       = 32'h0;
      memWriteAck          = 1'b0;
      cycle();
      check_reset_outputs("rst");
      rstN = 1'b1;
      cycle();

      // size=8, two lines, one-cycle ack
      send_line(32'h1122_3344, 1, 32'h0);
      check_val("t1_bytes1", bytesWritten, 32'd4);
      check_val("t1_addr1",  memWriteAddr, 32'h4);
      check_val("t1_ldone1", loadDone, 0);
      check_val("t1_cpurn1", cpuResetN, 0);
      send_line(32'h5566_7788, 1, 32'h4);
      check_val("t1_bytes2", bytesWritten, 32'd8);
      check_val("t1_ldone2", loadDone, 1);
      check_val("t1_cpurn2", cpuResetN, 1);
      check_val("t1_writes", wr_cnt, 2);

      // third line after DONE: acked, not written
      dc0 = done_cnt;
      wc0 = wr_cnt;
      seen_req  = 1'b0;
      seen_done = 1'b0;
      uartWriteValue  = 32'hDEAD_BEEF;
      uartWriteEnable = 1'b1;
      for (int i = 0; i < 10; i++) begin
         cycle();
         if (memWriteReq) seen_req = 1'b1;
         if (uartWriteDone) begin
            seen_done = 1'b1;
            break;
         end
      end
      uartWriteEnable = 1'b0;
      cycle();
      cycle();
      check_val("t2_done_seen", seen_done, 1);
      check_val("t2_no_req", seen_req, 0);
      check_val("t2_done_once", done_cnt - dc0, 1);
      check_val("t2_no_write", wr_cnt - wc0, 0);
      check_val("t2_bytes", bytesWritten, 32'd8);
      check_val("t2_ldone", loadDone, 1);

      // size=6, ack delayed 5 cycles; done only after second line
      totalMemoryWriteSize = 32'd6;
      do_reset();
      check_reset_outputs("rst2");
      send_line(32'hCAFE_0001, 5, 32'h0);
      check_val("t3_bytes1", bytesWritten, 32'd4);
      check_val("t3_ldone1", loadDone, 0);
      send_line(32'hCAFE_0002, 5, 32'h4);
      check_val("t3_bytes2", bytesWritten, 32'd8);
      check_val("t3_ldone2", loadDone, 1);
      check_val("t3_cpurn2", cpuResetN, 1);

      // async reset in the middle of line 2's write
      totalMemoryWriteSize = 32'd8;
      do_reset();
      send_line(32'h0BAD_F00D, 1, 32'h0);
      uartWriteValue  = 32'h1357_9BDF;
      uartWriteEnable = 1'b1;
      wait_req(ok);
      check_val("t4_req_up", ok, 1);
      check_val("t4_addr", memWriteAddr, 32'h4);
      #2 rstN = 1'b0;
      #1;
      check_reset_outputs("t4_async");
      uartWriteEnable = 1'b0;
      cycle();
      #3 rstN = 1'b1;
      cycle();
      send_line(32'hA5A5_5A5A, 1, 32'h0);
      check_val("t4_bytes", bytesWritten, 32'd4);

      // size=0: never finish
      totalMemoryWriteSize = 32'd0;
      do_reset();
      send_line(32'h0000_0001, 1, 32'h0);
      send_line(32'h0000_0002, 2, 32'h4);
      send_line(32'h0000_0003, 1, 32'h8);
      check_val("t5_bytes", bytesWritten, 32'd12);
      check_val("t5_addr", memWriteAddr, 32'hC);
      check_val("t5_ldone", loadDone, 0);
      check_val("t5_cpurn", cpuResetN, 0);

`ifdef UART_LOADER_TIMEOUT_EN
      // no ack: req drops after TbTimeout cycles, error is sticky
      totalMemoryWriteSize = 32'd8;
      do_reset();
      uartWriteValue  = 32'h7777_7777;
      uartWriteEnable = 1'b1;
      wait_req(ok);
      check_val("t6_req_up", ok, 1);
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
         if (!memWriteReq) break;
         cnt++;
         cycle();
      end
      check_val("t6_req_cycles", cnt, TbTimeout);
      check_val("t6_lerr", loadError, 1);
      check_val("t6_cpurn", cpuResetN, 0);
      check_val("t6_ldone", loadDone, 0);
      cycle();
      check_val("t6_err_ack", uartWriteDone, 1);
      uartWriteEnable = 1'b0;
      cycle();
      cycle();
      check_val("t6_lerr_sticky", loadError, 1);
      check_val("t6_cpurn_hold", cpuResetN, 0);
`else
      cnt = 0;
      check_val("t6_lerr_tied", loadError, cnt[0]);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
